cache_axi_bridge: RTL and testbench
===================================

CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

Interface
REQ-001 SHALL have one parameter: LINE_ALIGN, default 1. When 1, the low 4 address bits are forced to 0 on araddr/awaddr. When 0, the address is passed unchanged.
REQ-002 SHALL use a single clock, clk. Reset is resetn, asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 rd_req  in  1  cache line-refill request.
REQ-006 rd_addr  in  32  refill physical address.
REQ-007 rd_rdy  out  1  bridge can accept rd_req this cycle.
REQ-008 ret_valid  out  1  one-cycle pulse: ret_data holds the full line.
REQ-009 ret_data  out  128  refilled line; word i at [32*i+31:32*i].
REQ-010 wr_req  in  1  dirty-line write-back request.
REQ-011 wr_addr  in  32  write-back address.
REQ-012 wr_data  in  128  write-back line, same word order as ret_data.
REQ-013 wr_rdy  out  1  bridge can accept wr_req this cycle.
REQ-014 wr_valid  out  1  one-cycle pulse: write-back completed (B response received).
REQ-015 araddr/arvalid  out  32/1  AXI4 read address channel.
REQ-016 arready  in  1  AXI read address ready.
REQ-017 rdata/rvalid/rlast  in  32/1/1  AXI read data channel.
REQ-018 rready  out  1  AXI read data ready.
REQ-019 awaddr/awvalid  out  32/1  AXI4 write address channel.
REQ-020 awready  in  1  AXI write address ready.
REQ-021 wdata/wvalid/wlast  out  32/1/1  AXI write data channel.
REQ-022 wready  in  1  AXI write data ready.
REQ-023 bvalid  in  1; bready  out  1  AXI write response channel.
REQ-024 Fixed AXI fields SHALL be tied at top level: len=3, size=2, burst=INCR, wstrb=4'hF, id=0. rresp and bresp are ignored.

Function
REQ-025 The read FSM SHALL have states R_IDLE, R_AR, R_DATA, R_DONE. The write FSM SHALL have states W_IDLE, W_AW, W_DATA, W_RESP, W_DONE. The two FSMs run concurrently.
REQ-026 rd_rdy SHALL be 1 only in R_IDLE, and only when no conflict per REQ-035 exists. wr_rdy SHALL be 1 only in W_IDLE.
REQ-027 On rd_req&&rd_rdy the bridge SHALL latch the address, clear the beat counter, and go to R_AR.
REQ-028 In R_AR, arvalid SHALL be held at 1 with araddr stable until arready, then the FSM goes to R_DATA. arvalid SHALL never drop before arready.
REQ-029 In R_DATA, rready SHALL be 1. Each rvalid beat SHALL write word[cnt] and increment the 2-bit counter. The 4th beat (cnt==3) SHALL move the FSM to R_DONE. rlast is not used for termination.
REQ-030 In R_DONE, ret_valid SHALL be 1 for exactly one cycle with all 4 words valid, then the FSM returns to R_IDLE. ret_data SHALL hold its value until the next refill writes it.
REQ-031 On wr_req&&wr_rdy the bridge SHALL latch the address and the 128-bit data, clear the counter, and go to W_AW.
REQ-032 In W_AW, awvalid SHALL be held at 1 until awready, then the FSM goes to W_DATA.
REQ-033 In W_DATA, wvalid SHALL be 1 with wdata=line[32*cnt+:32] and wlast=(cnt==3). Each wready advances cnt. The handshake at cnt==3 SHALL move the FSM to W_RESP.
REQ-034 In W_RESP, bready SHALL be 1. bvalid SHALL move the FSM to W_DONE. In W_DONE, wr_valid SHALL be 1 for one cycle, then the FSM returns to W_IDLE.
REQ-035 Hazard rule: rd_rdy SHALL be 0 while the write FSM is not in W_IDLE and rd_addr[31:4] equals the latched write address [31:4].
REQ-036 Simultaneous rd_req and wr_req to the same line in the same cycle: the write SHALL be accepted first and the read stalls.
REQ-037 Simultaneous requests to different lines SHALL both be accepted in the same cycle.
REQ-038 Minimum read latency with zero-wait AXI: accept at cycle 0, arvalid at cycle 1, beats at cycles 2-5, ret_valid at cycle 6.

Reset
REQ-039 While resetn=0, both FSMs SHALL be idle and counters 0. Outputs: rd_rdy=1, wr_rdy=1, ret_data=0, and all valid/ready/last outputs 0. This applies mid-transaction too; the partial line and the pending write are dropped.

Verification
REQ-040 Refill of 0x1FC0_0014 with beats 0xA,0xB,0xC,0xD -> araddr=0x1FC0_0010; ret_valid pulses once; ret_data=0x0000000D_0000000C_0000000B_0000000A.
REQ-041 Write-back of 0x8000_0020 with data 0x44..33..22..11 -> awaddr=0x8000_0020; wdata sequence 0x11,0x22,0x33,0x44 with wlast on the 4th beat; wr_valid pulses one cycle after bvalid.
REQ-042 Backpressure (arready delayed 3 cycles, wready toggling) -> arvalid, araddr, wvalid, and wdata stay stable until the handshake; word order is preserved.
REQ-043 Write to line 0x100 pending while a read to 0x104 is presented -> rd_rdy=0 until W_DONE, then the read is accepted. A read to 0x200 is accepted immediately.
REQ-044 resetn pulled low after the 2nd read beat -> all outputs return to their reset values at once; ret_valid never pulses for that read.

Source files
------------

// File: rtl/cache_axi_bridge_if.sv
// Bundle of cache-side refill/write-back handshakes and the AXI4 master channels.
// The bridge connects through modport master; the cache/AXI environment through modport slave.
interface cache_axi_bridge_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LINE_W = 128;

  // cache refill side
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_rdy;
  logic              ret_valid;
  logic [LINE_W-1:0] ret_data;

  // cache write-back side
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0] wr_data;
  logic              wr_rdy;
  logic              wr_valid;

  // AXI read address / data
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [3:0]        arid;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rlast;
  logic              rready;

  // AXI write address / data / response
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [3:0]        awid;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wlast;
  logic              wready;
  logic              bvalid;
  logic              bready;

  modport master (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data,
    output rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid,
    output araddr, arvalid, arlen, arsize, arburst, arid,
    input  arready,
    input  rdata, rvalid, rlast,
    output rready,
    output awaddr, awvalid, awlen, awsize, awburst, awid,
    input  awready,
    output wdata, wstrb, wvalid, wlast,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data,
    input  rd_rdy, ret_valid, ret_data, wr_rdy, wr_valid,
    input  araddr, arvalid, arlen, arsize, arburst, arid,
    output arready,
    output rdata, rvalid, rlast,
    input  rready,
    input  awaddr, awvalid, awlen, awsize, awburst, awid,
    output awready,
    input  wdata, wstrb, wvalid, wlast,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// Cache line refill / write-back to AXI4 bridge: 4-beat INCR bursts of 32-bit words,
// independent read and write FSMs with a same-line read-after-write hazard stall.
module cache_axi_bridge #(
  parameter bit LINE_ALIGN = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  cache_axi_bridge_if.master   bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned CNT_W  = 2;
  localparam int unsigned OFF_W  = 4;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} r_state_e;
  typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_RESP, W_DONE} w_state_e;

  r_state_e            r_state_q;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [CNT_W-1:0]    r_cnt_q;
  logic [LINE_W-1:0]   r_line_q;
  logic                ar_valid_q;
  logic                r_ready_q;
  logic                ret_valid_q;

  w_state_e            w_state_q;
  logic [ADDR_W-1:0]   w_addr_q;
  logic [CNT_W-1:0]    w_cnt_q;
  logic [CNT_W-1:0]    w_cnt_d;
  logic [LINE_W-1:0]   w_line_q;
  logic [DATA_W-1:0]   w_data_q;
  logic                aw_valid_q;
  logic                w_valid_q;
  logic                w_last_q;
  logic                b_ready_q;
  logic                wr_valid_q;

  logic                hit_pending_c;
  logic                hit_same_cycle_c;
  logic                rd_rdy_c;
  logic                wr_rdy_c;
  logic                unused_rlast;

  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    return LINE_ALIGN ? {a[ADDR_W-1:OFF_W], OFF_W'(0)} : a;
  endfunction

  // A read may not overtake a write-back to the same line, pending or arriving this cycle.
  assign hit_pending_c    = (w_state_q != W_IDLE) &&
                            (bus.rd_addr[ADDR_W-1:OFF_W] == w_addr_q[ADDR_W-1:OFF_W]);
  assign hit_same_cycle_c = (w_state_q == W_IDLE) && bus.wr_req &&
                            (bus.rd_addr[ADDR_W-1:OFF_W] == bus.wr_addr[ADDR_W-1:OFF_W]);
  assign rd_rdy_c         = (r_state_q == R_IDLE) && !hit_pending_c && !hit_same_cycle_c;
  assign wr_rdy_c         = (w_state_q == W_IDLE);
  assign w_cnt_d          = w_cnt_q + CNT_W'(1);

  // Read FSM: AR handshake, four R beats into the line buffer, one-cycle return pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_q   <= R_IDLE;
      r_addr_q    <= '0;
      r_cnt_q     <= '0;
      r_line_q    <= '0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      ret_valid_q <= 1'b0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (bus.rd_req && rd_rdy_c) begin
            r_addr_q   <= align_addr(bus.rd_addr);
            r_cnt_q    <= '0;
            ar_valid_q <= 1'b1;
            r_state_q  <= R_AR;
          end
        end
        R_AR: begin
          if (bus.arready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            r_state_q  <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.rvalid) begin
            r_line_q[{r_cnt_q, 5'd0} +: DATA_W] <= bus.rdata;
            r_cnt_q <= r_cnt_q + CNT_W'(1);
            if (r_cnt_q == CNT_W'(3)) begin
              r_ready_q   <= 1'b0;
              ret_valid_q <= 1'b1;
              r_state_q   <= R_DONE;
            end
          end
        end
        R_DONE: begin
          ret_valid_q <= 1'b0;
          r_state_q   <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  // Write FSM: AW handshake, four W beats from the latched line, wait for B, completion pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_q  <= W_IDLE;
      w_addr_q   <= '0;
      w_cnt_q    <= '0;
      w_line_q   <= '0;
      w_data_q   <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      w_last_q   <= 1'b0;
      b_ready_q  <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (bus.wr_req) begin
            w_addr_q   <= align_addr(bus.wr_addr);
            w_line_q   <= bus.wr_data;
            w_cnt_q    <= '0;
            aw_valid_q <= 1'b1;
            w_state_q  <= W_AW;
          end
        end
        W_AW: begin
          if (bus.awready) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b1;
            w_data_q   <= w_line_q[DATA_W-1:0];
            w_last_q   <= 1'b0;
            w_state_q  <= W_DATA;
          end
        end
        W_DATA: begin
          if (bus.wready) begin
            if (w_cnt_q == CNT_W'(3)) begin
              w_valid_q <= 1'b0;
              w_last_q  <= 1'b0;
              b_ready_q <= 1'b1;
              w_state_q <= W_RESP;
            end else begin
              w_cnt_q  <= w_cnt_d;
              w_data_q <= w_line_q[{w_cnt_d, 5'd0} +: DATA_W];
              w_last_q <= (w_cnt_d == CNT_W'(3));
            end
          end
        end
        W_RESP: begin
          if (bus.bvalid) begin
            b_ready_q  <= 1'b0;
            wr_valid_q <= 1'b1;
            w_state_q  <= W_DONE;
          end
        end
        W_DONE: begin
          wr_valid_q <= 1'b0;
          w_state_q  <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign bus.rd_rdy    = rd_rdy_c;
  assign bus.wr_rdy    = wr_rdy_c;
  assign bus.ret_valid = ret_valid_q;
  assign bus.ret_data  = r_line_q;
  assign bus.wr_valid  = wr_valid_q;

  assign bus.araddr    = r_addr_q;
  assign bus.arvalid   = ar_valid_q;
  assign bus.rready    = r_ready_q;
  assign bus.awaddr    = w_addr_q;
  assign bus.awvalid   = aw_valid_q;
  assign bus.wdata     = w_data_q;
  assign bus.wvalid    = w_valid_q;
  assign bus.wlast     = w_last_q;
  assign bus.bready    = b_ready_q;

  // Fixed burst shape: 4 beats of 4 bytes, incrementing, single ID, full strobes.
  assign bus.arlen     = 8'd3;
  assign bus.arsize    = 3'd2;
  assign bus.arburst   = 2'b01;
  assign bus.arid      = 4'd0;
  assign bus.awlen     = 8'd3;
  assign bus.awsize    = 3'd2;
  assign bus.awburst   = 2'b01;
  assign bus.awid      = 4'd0;
  assign bus.wstrb     = 4'hF;

  // Burst length is counted locally, so rlast carries no information here.
  assign unused_rlast  = bus.rlast;
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: refill, write-back, backpressure, hazards, mid-burst reset.
module tb_cache_axi_bridge;
  logic clk;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  cache_axi_bridge_if bus();

  cache_axi_bridge #(.LINE_ALIGN(1'b1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic read_accept(input logic [31:0] addr, input logic [31:0] exp_addr);
    @(negedge clk);
    bus.rd_req  = 1'b1;
    bus.rd_addr = addr;
    #1 check("rd_rdy_accept", bus.rd_rdy, 1'b1);
    @(negedge clk);
    bus.rd_req = 1'b0;
    #1;
    check("arvalid_up", bus.arvalid, 1'b1);
    check("araddr", bus.araddr, exp_addr);
  endtask

  task automatic read_finish(input logic [31:0] exp_addr, input logic [127:0] line,
                             input int ar_delay, input bit gap);
    for (int d = 0; d < ar_delay; d++) begin
      check("arvalid_hold", bus.arvalid, 1'b1);
      check("araddr_hold", bus.araddr, exp_addr);
      @(negedge clk); #1;
    end
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    #1;
    check("rready_up", bus.rready, 1'b1);
    check("arvalid_down", bus.arvalid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (gap && i == 1) begin
        bus.rvalid = 1'b0;
        @(negedge clk);
      end
      bus.rvalid = 1'b1;
      bus.rdata  = line[32*i +: 32];
      bus.rlast  = (i == 3);
      if (i == 3) check("ret_valid_early", bus.ret_valid, 1'b0);
      @(negedge clk);
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    #1;
    check("ret_valid_pulse", bus.ret_valid, 1'b1);
    check("ret_data", bus.ret_data, line);
    check("rready_down", bus.rready, 1'b0);
    @(negedge clk); #1;
    check("ret_valid_low", bus.ret_valid, 1'b0);
    check("ret_data_hold", bus.ret_data, line);
  endtask

  task automatic write_accept(input logic [31:0] addr, input logic [127:0] data,
                              input logic [31:0] exp_addr);
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    #1 check("wr_rdy_accept", bus.wr_rdy, 1'b1);
    @(negedge clk);
    bus.wr_req = 1'b0;
    #1;
    check("awvalid_up", bus.awvalid, 1'b1);
    check("awaddr", bus.awaddr, exp_addr);
  endtask

  task automatic write_finish(input logic [31:0] exp_addr, input logic [127:0] line,
                              input int aw_delay, input bit toggle);
    for (int d = 0; d < aw_delay; d++) begin
      check("awvalid_hold", bus.awvalid, 1'b1);
      check("awaddr_hold", bus.awaddr, exp_addr);
      @(negedge clk); #1;
    end
    bus.awready = 1'b1;
    @(negedge clk);
    bus.awready = 1'b0;
    #1;
    check("awvalid_down", bus.awvalid, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("wvalid", bus.wvalid, 1'b1);
      check("wdata", bus.wdata, line[32*i +: 32]);
      check("wlast", bus.wlast, (i == 3));
      if (toggle) begin
        bus.wready = 1'b0;
        @(negedge clk); #1;
        check("wvalid_hold", bus.wvalid, 1'b1);
        check("wdata_hold", bus.wdata, line[32*i +: 32]);
      end
      bus.wready = 1'b1;
      @(negedge clk);
      bus.wready = 1'b0;
      #1;
    end
    check("wvalid_down", bus.wvalid, 1'b0);
    check("bready_up", bus.bready, 1'b1);
    if (toggle) begin
      @(negedge clk); #1;
      check("wr_valid_wait_b", bus.wr_valid, 1'b0);
    end
    bus.bvalid = 1'b1;
    @(negedge clk);
    bus.bvalid = 1'b0;
    #1;
    check("wr_valid_pulse", bus.wr_valid, 1'b1);
    check("bready_down", bus.bready, 1'b0);
    @(negedge clk); #1;
    check("wr_valid_low", bus.wr_valid, 1'b0);
    check("wr_rdy_idle", bus.wr_rdy, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] l0;
    logic [127:0] l1;
    logic [127:0] d0;
    logic [127:0] d1;
    resetn      = 1'b0;
    bus.rd_req  = 1'b0;
    bus.rd_addr = '0;
    bus.wr_req  = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.arready = 1'b0;
    bus.rdata   = '0;
    bus.rvalid  = 1'b0;
    bus.rlast   = 1'b0;
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rd_rdy", bus.rd_rdy, 1'b1);
    check("rst_wr_rdy", bus.wr_rdy, 1'b1);
    check("rst_ret_data", bus.ret_data, 128'h0);
    check("rst_valids", {bus.ret_valid, bus.wr_valid, bus.arvalid, bus.rready,
                         bus.awvalid, bus.wvalid, bus.wlast, bus.bready}, 8'h00);
    check("ar_fixed", {bus.arlen, bus.arsize, bus.arburst, bus.arid}, {8'd3, 3'd2, 2'b01, 4'd0});
    check("aw_fixed", {bus.awlen, bus.awsize, bus.awburst, bus.awid, bus.wstrb},
          {8'd3, 3'd2, 2'b01, 4'd0, 4'hF});
    @(negedge clk);
    resetn = 1'b1;

    // basic refill with address alignment, zero-wait AXI
    l0 = {32'h0000000D, 32'h0000000C, 32'h0000000B, 32'h0000000A};
    read_accept(32'h1FC0_0014, 32'h1FC0_0010);
    read_finish(32'h1FC0_0010, l0, 0, 1'b0);

    // basic write-back
    d0 = {32'h44, 32'h33, 32'h22, 32'h11};
    write_accept(32'h8000_0020, d0, 32'h8000_0020);
    write_finish(32'h8000_0020, d0, 0, 1'b0);

    // backpressure on AR/AW, gap on R, toggling wready
    l1 = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
    read_accept(32'h2000_0038, 32'h2000_0030);
    read_finish(32'h2000_0030, l1, 3, 1'b1);
    d1 = {32'hDEAD0004, 32'hBEEF0003, 32'h12340002, 32'h56780001};
    write_accept(32'h9000_0044, d1, 32'h9000_0040);
    write_finish(32'h9000_0040, d1, 3, 1'b1);

    // pending write to line 0x100 blocks a read to 0x104, not one to 0x200
    write_accept(32'h0000_0100, d0, 32'h0000_0100);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 32'h0000_0104;
    #1 check("hazard_rd_rdy", bus.rd_rdy, 1'b0);
    bus.rd_addr = 32'h0000_0200;
    #1 check("other_line_rd_rdy", bus.rd_rdy, 1'b1);
    @(negedge clk);
    bus.rd_req = 1'b0;
    #1;
    check("other_line_arvalid", bus.arvalid, 1'b1);
    check("other_line_araddr", bus.araddr, 32'h0000_0200);
    read_finish(32'h0000_0200, l1, 0, 1'b0);
    bus.rd_req  = 1'b1;
    bus.rd_addr = 32'h0000_0104;
    #1 check("hazard_rd_rdy_2", bus.rd_rdy, 1'b0);
    write_finish(32'h0000_0100, d0, 0, 1'b0);
    check("hazard_not_accepted", bus.arvalid, 1'b0);
    check("hazard_released", bus.rd_rdy, 1'b1);
    @(negedge clk);
    bus.rd_req = 1'b0;
    #1;
    check("hazard_arvalid", bus.arvalid, 1'b1);
    check("hazard_araddr", bus.araddr, 32'h0000_0100);
    read_finish(32'h0000_0100, l0, 0, 1'b0);

    // simultaneous requests to the same line: write wins
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.wr_addr = 32'h0000_0300;
    bus.wr_data = d1;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 32'h0000_0308;
    #1;
    check("same_line_wr_rdy", bus.wr_rdy, 1'b1);
    check("same_line_rd_rdy", bus.rd_rdy, 1'b0);
    @(negedge clk);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    #1;
    check("same_line_awvalid", bus.awvalid, 1'b1);
    check("same_line_arvalid", bus.arvalid, 1'b0);
    write_finish(32'h0000_0300, d1, 0, 1'b0);

    // simultaneous requests to different lines: both accepted
    @(negedge clk);
    bus.wr_req  = 1'b1;
    bus.wr_addr = 32'h0000_0400;
    bus.wr_data = d0;
    bus.rd_req  = 1'b1;
    bus.rd_addr = 32'h0000_0500;
    #1;
    check("diff_line_rdys", {bus.wr_rdy, bus.rd_rdy}, 2'b11);
    @(negedge clk);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    #1;
    check("diff_line_valids", {bus.awvalid, bus.arvalid}, 2'b11);
    read_finish(32'h0000_0500, l1, 0, 1'b0);
    write_finish(32'h0000_0400, d0, 0, 1'b0);

    // reset after the second read beat drops the refill
    read_accept(32'h0000_0600, 32'h0000_0600);
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    bus.rvalid  = 1'b1;
    bus.rdata   = 32'h1111_0000;
    @(negedge clk);
    bus.rdata   = 32'h1111_0001;
    @(negedge clk);
    bus.rvalid  = 1'b0;
    resetn      = 1'b0;
    #1;
    check("midrst_ret_data", bus.ret_data, 128'h0);
    check("midrst_valids", {bus.ret_valid, bus.arvalid, bus.rready, bus.awvalid,
                            bus.wvalid, bus.wlast, bus.bready, bus.wr_valid}, 8'h00);
    check("midrst_rdys", {bus.rd_rdy, bus.wr_rdy}, 2'b11);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.rvalid = 1'b1;
      bus.rdata  = 32'h2222_0000;
      @(negedge clk); #1;
      check("midrst_no_ret_valid", bus.ret_valid, 1'b0);
    end
    bus.rvalid = 1'b0;
    read_accept(32'h0000_0700, 32'h0000_0700);
    read_finish(32'h0000_0700, l0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
